// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: branch kinds, the EX/MEM payload and trap vector.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_EQ   = 2'd1,
        BR_NE   = 2'd2
    } brtype_t;

    // Occupancy of the two-entry output buffer.
    typedef enum logic [1:0] {
        SK_EMPTY = 2'd0,
        SK_ONE   = 2'd1,
        SK_TWO   = 2'd2
    } skid_state_t;

    // Everything the memory stage sees for one instruction.
    typedef struct packed {
        word_t    aluout;
        logic     neg;
        regbits_t rd;
        logic     regwrite;
        logic     memread;
        logic     memwrite;
        logic     halt;
        word_t    store_data;
        word_t    pc;
    } exmem_t;

    localparam word_t EXC_VECTOR_DEFAULT = 32'h0000_0080;

endpackage

// File: rtl/ex_mem_stage_if.sv
// Valid/ready bus around a two-entry buffer: producer side, consumer side, kill.
interface ex_mem_stage_if #(parameter type T = cpu_types_pkg::exmem_t);
    logic in_valid;
    logic in_ready;
    T     in_data;
    logic out_valid;
    logic out_ready;
    T     out_data;
    logic flush;

    // Owner of the buffer: pushes entries, pulls results.
    modport master (
        output in_valid, in_data, out_ready, flush,
        input  in_ready, out_valid, out_data
    );

    // The buffer itself.
    modport slave (
        input  in_valid, in_data, out_ready, flush,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/exmem_skid.sv
// Generic two-entry valid/ready buffer. Ready and valid come straight from the
// state register, so downstream back-pressure never reaches upstream combinationally.
module exmem_skid
    import cpu_types_pkg::*;
#(
    parameter type T = cpu_types_pkg::exmem_t
) (
    input  logic CLK,
    input  logic nRST,
    ex_mem_stage_if.slave bus
);

    skid_state_t state_q, state_d;
    T            main_q, main_d;
    T            skid_q, skid_d;
    logic        accept, emit;

    assign bus.in_ready  = (state_q != SK_TWO);
    assign bus.out_valid = (state_q != SK_EMPTY);
    assign bus.out_data  = main_q;

    assign accept = bus.in_valid && bus.in_ready;
    assign emit   = bus.out_valid && bus.out_ready;

    // Occupancy and data movement: main always feeds the output, skid catches
    // the one entry that arrives while the output is stalled.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (bus.flush) begin
            state_d = SK_EMPTY;
        end else begin
            unique case (state_q)
                SK_EMPTY: begin
                    if (accept) begin
                        main_d  = bus.in_data;
                        state_d = SK_ONE;
                    end
                end
                SK_ONE: begin
                    if (accept && emit) begin
                        main_d = bus.in_data;
                    end else if (accept) begin
                        skid_d  = bus.in_data;
                        state_d = SK_TWO;
                    end else if (emit) begin
                        state_d = SK_EMPTY;
                    end
                end
                SK_TWO: begin
                    if (emit) begin
                        main_d  = skid_q;
                        state_d = SK_ONE;
                    end
                end
                default: state_d = SK_EMPTY;
            endcase
        end
    end

    // State and entry registers; reset clears data so mem_* outputs read 0.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= SK_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: resolves BEQ/BNE, traps signed overflow and hands
// the result to memory through a two-entry skid buffer.
module ex_mem_stage
    import cpu_types_pkg::*;
#(
    parameter word_t EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
    input  logic     CLK,
    input  logic     nRST,
    input  logic     ex_valid,
    output logic     ex_ready,
    input  word_t    aluout,
    input  logic     zero,
    input  logic     neg,
    input  logic     over,
    input  brtype_t  br_type,
    input  word_t    br_target,
    input  word_t    pc,
    input  logic     check_over,
    input  regbits_t rd,
    input  logic     regwrite,
    input  logic     memread,
    input  logic     memwrite,
    input  logic     halt,
    input  word_t    store_data,
    input  logic     flush,
    output logic     mem_valid,
    input  logic     mem_ready,
    output word_t    mem_aluout,
    output logic     mem_neg,
    output regbits_t mem_rd,
    output logic     mem_regwrite,
    output logic     mem_memread,
    output logic     mem_memwrite,
    output logic     mem_halt,
    output word_t    mem_store_data,
    output word_t    mem_pc,
    output logic     redirect,
    output word_t    redirect_pc,
    output logic     exc_over,
    output word_t    epc
);

    ex_mem_stage_if #(.T(exmem_t)) sk_if ();

    exmem_skid #(.T(exmem_t)) u_skid (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (sk_if.slave)
    );

    logic  taken, trap, acc;
    exmem_t ent;
    logic  redirect_q, redirect_d;
    word_t redirect_pc_q, redirect_pc_d;
    logic  exc_over_q, exc_over_d;
    word_t epc_q, epc_d;

    // Decode the incoming entry; a trapping instruction must not touch
    // registers or memory, so its side-effect bits are stripped here.
    always_comb begin
        taken = ((br_type == BR_EQ) && zero) || ((br_type == BR_NE) && !zero);
        trap  = check_over && over;
        acc   = ex_valid && sk_if.in_ready && !flush;
        ent.aluout     = aluout;
        ent.neg        = neg;
        ent.rd         = rd;
        ent.regwrite   = regwrite && !trap;
        ent.memread    = memread && !trap;
        ent.memwrite   = memwrite && !trap;
        ent.halt       = halt;
        ent.store_data = store_data;
        ent.pc         = pc;
    end

    assign sk_if.in_valid  = ex_valid;
    assign sk_if.in_data   = ent;
    assign sk_if.out_ready = mem_ready;
    assign sk_if.flush     = flush;

    // Next values of the redirect/trap pulses; trap wins over a taken branch.
    always_comb begin
        redirect_d    = acc && (trap || taken);
        redirect_pc_d = redirect_pc_q;
        exc_over_d    = acc && trap;
        epc_d         = epc_q;
        if (acc && trap) begin
            redirect_pc_d = EXC_VECTOR;
            epc_d         = pc;
        end else if (acc && taken) begin
            redirect_pc_d = br_target;
        end
    end

    // Pulse registers; epc and redirect_pc hold until the next event.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            exc_over_q    <= 1'b0;
            epc_q         <= '0;
        end else begin
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            exc_over_q    <= exc_over_d;
            epc_q         <= epc_d;
        end
    end

    assign ex_ready       = sk_if.in_ready;
    assign mem_valid      = sk_if.out_valid;
    assign mem_aluout     = sk_if.out_data.aluout;
    assign mem_neg        = sk_if.out_data.neg;
    assign mem_rd         = sk_if.out_data.rd;
    assign mem_regwrite   = sk_if.out_data.regwrite;
    assign mem_memread    = sk_if.out_data.memread;
    assign mem_memwrite   = sk_if.out_data.memwrite;
    assign mem_halt       = sk_if.out_data.halt;
    assign mem_store_data = sk_if.out_data.store_data;
    assign mem_pc         = sk_if.out_data.pc;
    assign redirect       = redirect_q;
    assign redirect_pc    = redirect_pc_q;
    assign exc_over       = exc_over_q;
    assign epc            = epc_q;

endmodule
